// File: rtl/alu_reg_sequencer.sv
// Operand/writeback sequencer wrapped around a combinational ALU: it owns an
// 8-entry register file and a flag register, and runs one instruction at a time.
module alu_reg_sequencer #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_ld,
    input  logic [2:0]       in_op,
    input  logic [2:0]       in_rd,
    input  logic [2:0]       in_ra,
    input  logic [2:0]       in_rb,
    input  logic [width-1:0] in_imm,
    output logic [width-1:0] alu_a,
    output logic [width-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [width-1:0] alu_y,
    input  logic [2:0]       alu_onz,
    output logic [2:0]       flags,
    output logic             done,
    input  logic [2:0]       dbg_addr,
    output logic [width-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t           state;
    logic             ld_q;
    logic [2:0]       op_q;
    logic [2:0]       rd_q;
    logic [2:0]       ra_q;
    logic [2:0]       rb_q;
    logic [width-1:0] imm_q;
    logic [width-1:0] res;
    logic [width-1:0] regs [8];

    // Plain combinational read: a write in WB becomes visible one cycle later.
    assign dbg_data = regs[dbg_addr];

    // in_ready and done are registered alongside the state so each mirrors
    // exactly one state (IDLE and WB respectively).
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            done     <= 1'b0;
            ld_q     <= 1'b0;
            op_q     <= '0;
            rd_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            imm_q    <= '0;
            res      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            flags    <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ld_q     <= in_ld;
                        op_q     <= in_op;
                        rd_q     <= in_rd;
                        ra_q     <= in_ra;
                        rb_q     <= in_rb;
                        imm_q    <= in_imm;
                        in_ready <= 1'b0;
                        if (in_ld) begin
                            state <= WB;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    // Operands are captured here, so a writeback to ra/rb later
                    // in this instruction cannot disturb them.
                    alu_a  <= regs[ra_q];
                    alu_b  <= regs[rb_q];
                    alu_op <= op_q;
                    state  <= EXEC;
                end
                EXEC: begin
                    res   <= alu_y;
                    flags <= alu_onz;
                    done  <= 1'b1;
                    state <= WB;
                end
                WB: begin
                    regs[rd_q] <= ld_q ? imm_q : res;
                    done       <= 1'b0;
                    in_ready   <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Self-checking bench for alu_reg_sequencer: a behavioural ALU drives the
// result inputs, and a register/flag array model predicts every writeback.
module tb_alu_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_ld;
    logic [2:0] in_op, in_rd, in_ra, in_rb;
    logic [7:0] in_imm;
    logic [7:0] alu_a, alu_b, alu_y;
    logic [2:0] alu_op, alu_onz;
    logic [2:0] flags;
    logic       done;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [7:0] model_r [8];
    logic [2:0] model_f;

    alu_reg_sequencer #(.width(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ld(in_ld), .in_op(in_op), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
        .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_onz(alu_onz), .flags(flags), .done(done),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    // Reference ALU: returns {O,N,Z,y}; overflow judged on true signed results.
    function automatic logic [10:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, s;
        logic [7:0] y;
        logic o;
        sa = int'($signed(a));
        sb = int'($signed(b));
        o  = 1'b0;
        case (op)
            3'd0: begin y = a + b; s = sa + sb; o = (s > 127) || (s < -128); end
            3'd1: begin y = a - b; s = sa - sb; o = (s > 127) || (s < -128); end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: begin y = a + 8'd1; s = sa + 1; o = (s > 127); end
            3'd6: y = a;
            default: y = b;
        endcase
        return {o, y[7], (y == 8'd0), y};
    endfunction

    always_comb {alu_onz, alu_y} = alu_ref(alu_op, alu_a, alu_b);

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_r[i] = 8'd0;
        model_f = 3'b000;
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [7:0] val);
        dbg_addr = idx;
        #1;
        val = dbg_data;
    endtask

    // Issue one instruction from a negedge and follow it through writeback,
    // checking latency, old/new debug value and flags against the model.
    task automatic exec_instr(input bit ld, input logic [2:0] op, input logic [2:0] rd,
                              input logic [2:0] ra, input logic [2:0] rb, input logic [7:0] imm);
        int n;
        logic [7:0] exp_y, v;
        logic [2:0] exp_f;
        in_valid = 1'b1; in_ld = ld; in_op = op; in_rd = rd; in_ra = ra; in_rb = rb; in_imm = imm;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        if (ld) begin exp_y = imm; exp_f = model_f; end
        else {exp_f, exp_y} = alu_ref(op, model_r[ra], model_r[rb]);
        @(negedge clk);
        in_valid = 1'b0;
        {in_ld, in_op, in_rd, in_ra, in_rb, in_imm} = 18'($urandom);
        n = 1;
        while (!done && n < 10) begin @(negedge clk); n++; end
        tests++;
        if (n !== (ld ? 1 : 3)) begin
            fails++; $display("FAIL done_latency: got %0d cycles required %0d", n, ld ? 1 : 3);
        end
        read_reg(rd, v);
        tests++;
        if (v !== model_r[rd]) begin
            fails++; $display("FAIL wb_old_value: R%0d=%h required %h", rd, v, model_r[rd]);
        end
        tests++;
        if (flags !== exp_f) begin
            fails++; $display("FAIL flags: got %b required %b (ld=%0d op=%0d)", flags, exp_f, ld, op);
        end
        @(negedge clk);
        read_reg(rd, v);
        tests++;
        if (done !== 1'b0 || v !== exp_y) begin
            fails++; $display("FAIL writeback: done=%b R%0d=%h required done=0 R=%h", done, rd, v, exp_y);
        end
        model_r[rd] = exp_y;
        model_f = exp_f;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        tests++;
        if (in_ready !== 1'b1 || flags !== 3'b000 || done !== 1'b0) begin
            fails++; $display("FAIL reset_outputs: ready=%b flags=%b done=%b required 1 000 0", in_ready, flags, done);
        end
        tests++;
        if (alu_a !== 8'd0 || alu_b !== 8'd0 || alu_op !== 3'd0) begin
            fails++; $display("FAIL reset_alu_ports: a=%h b=%h op=%b required 0", alu_a, alu_b, alu_op);
        end
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), v);
            tests++;
            if (v !== 8'h00) begin
                fails++; $display("FAIL reset_reg: R%0d=%h required 00", i, v);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_load_add();
        logic [7:0] v;
        exec_instr(1, 3'd0, 3'd1, 3'd0, 3'd0, 8'h05);
        exec_instr(1, 3'd0, 3'd2, 3'd0, 3'd0, 8'h03);
        exec_instr(0, 3'd0, 3'd3, 3'd1, 3'd2, 8'h00);
        read_reg(3'd3, v);
        tests++;
        if (v !== 8'h08 || flags !== 3'b000) begin
            fails++; $display("FAIL load_add: R3=%h flags=%b required 08 000", v, flags);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        exec_instr(1, 3'd0, 3'd1, 3'd0, 3'd0, 8'h7F);
        exec_instr(1, 3'd0, 3'd2, 3'd0, 3'd0, 8'h01);
        exec_instr(0, 3'd0, 3'd4, 3'd1, 3'd2, 8'h00);
        read_reg(3'd4, v);
        tests++;
        if (v !== 8'h80 || flags !== 3'b110) begin
            fails++; $display("FAIL ovf_add: R4=%h flags=%b required 80 110", v, flags);
        end
        exec_instr(0, 3'd1, 3'd5, 3'd4, 3'd2, 8'h00);
        read_reg(3'd5, v);
        tests++;
        if (v !== 8'h7F || flags !== 3'b100) begin
            fails++; $display("FAIL ovf_sub: R5=%h flags=%b required 7f 100", v, flags);
        end
    endtask

    task automatic test_zero_alias();
        logic [7:0] v;
        exec_instr(0, 3'd1, 3'd1, 3'd1, 3'd1, 8'h00);
        read_reg(3'd1, v);
        tests++;
        if (v !== 8'h00 || flags !== 3'b001) begin
            fails++; $display("FAIL alias_sub: R1=%h flags=%b required 00 001", v, flags);
        end
        exec_instr(1, 3'd0, 3'd6, 3'd0, 3'd0, 8'hFF);
        exec_instr(0, 3'd5, 3'd6, 3'd6, 3'd0, 8'h00);
        read_reg(3'd6, v);
        tests++;
        if (v !== 8'h00 || flags !== 3'b001) begin
            fails++; $display("FAIL alias_inc: R6=%h flags=%b required 00 001", v, flags);
        end
    endtask

    // Two ALU ops with in_valid held high; the second depends on the first.
    task automatic test_stall();
        int n, d0;
        logic [7:0] v, e1, e2;
        exec_instr(1, 3'd0, 3'd0, 3'd0, 3'd0, 8'h3C);
        exec_instr(1, 3'd0, 3'd1, 3'd0, 3'd0, 8'h0F);
        e1 = 8'h3C ^ 8'h0F;
        e2 = e1 + e1;
        d0 = done_cnt;
        in_valid = 1'b1; in_ld = 0; in_op = 3'd4; in_rd = 3'd2; in_ra = 3'd0; in_rb = 3'd1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin in_op = 3'd0; in_rd = 3'd3; in_ra = 3'd2; in_rb = 3'd2; end
            tests++;
            if (in_ready !== 1'b0) begin
                fails++; $display("FAIL stall_ready: cycle %0d in_ready=%b required 0", c, in_ready);
            end
        end
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL stall_second_accept: in_ready=%b at cycle 4 required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        read_reg(3'd2, v);
        tests++;
        if (v !== e1) begin
            fails++; $display("FAIL stall_first: R2=%h required %h", v, e1);
        end
        read_reg(3'd3, v);
        tests++;
        if (v !== e2 || done_cnt - d0 !== 2) begin
            fails++; $display("FAIL stall_second: R3=%h dones=%0d required %h 2", v, done_cnt - d0, e2);
        end
        model_r[2] = e1;
        model_r[3] = e2;
        model_f = alu_ref(3'd0, e1, e1) >> 8;
    endtask

    // Two loads held back-to-back: accepted two cycles apart.
    task automatic test_back_to_back();
        logic [7:0] v;
        in_valid = 1'b1; in_ld = 1; in_rd = 3'd4; in_imm = 8'hA5;
        while (!in_ready) @(negedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || done !== 1'b1) begin
            fails++; $display("FAIL b2b_wb: ready=%b done=%b required 0 1", in_ready, done);
        end
        in_rd = 3'd5; in_imm = 8'h5A;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_accept: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        read_reg(3'd4, v);
        tests++;
        if (v !== 8'hA5) begin
            fails++; $display("FAIL b2b_first: R4=%h required a5", v);
        end
        read_reg(3'd5, v);
        tests++;
        if (v !== 8'h5A) begin
            fails++; $display("FAIL b2b_second: R5=%h required 5a", v);
        end
        model_r[4] = 8'hA5;
        model_r[5] = 8'h5A;
    endtask

    task automatic test_reset_mid();
        int n, d0;
        logic [7:0] v;
        exec_instr(1, 3'd0, 3'd7, 3'd0, 3'd0, 8'h0A);
        d0 = done_cnt;
        in_valid = 1'b1; in_ld = 0; in_op = 3'd0; in_rd = 3'd7; in_ra = 3'd7; in_rb = 3'd7;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        read_reg(3'd7, v);
        tests++;
        if (done !== 1'b0 || in_ready !== 1'b1 || flags !== 3'b000 || v !== 8'h00) begin
            fails++; $display("FAIL reset_mid: done=%b ready=%b flags=%b R7=%h required 0 1 000 00", done, in_ready, flags, v);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (done_cnt !== d0) begin
            fails++; $display("FAIL reset_mid_done: %0d done pulses required 0", done_cnt - d0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            exec_instr(($urandom_range(0, 2) == 0), 3'($urandom), 3'($urandom),
                       3'($urandom), 3'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ld = 0; in_op = 0; in_rd = 0; in_ra = 0; in_rb = 0;
        in_imm = 0; dbg_addr = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_load_add();
        test_overflow();
        test_zero_alias();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_reg_sequencer.md
# alu_reg_sequencer

Multi-cycle operand/writeback sequencer that sits directly upstream and downstream of the combinational ALU. It owns an 8-entry register file and a flag register, and accepts one instruction at a time over a valid/ready handshake. It drives the ALU operand and opcode inputs from registered values, captures the ALU result `Y` and flags `ONZ`, and writes the result back. It also supports a load-immediate instruction that bypasses the ALU.

## Interface

**Parameters**
- `width`, default 8: data width. Must equal the `width` parameter of the attached ALU instance.

**Ports**
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  sequencer can accept an instruction.
- `in_ld`  in  1  1 = load immediate `R[rd] <= in_imm`; 0 = ALU op.
- `in_op`  in  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 inc, 110 movA, 111 movB).
- `in_rd`  in  3  destination register index.
- `in_ra`  in  3  source A register index.
- `in_rb`  in  3  source B register index.
- `in_imm`  in  width  immediate for load.
- `alu_a`  out  width  registered operand A to the ALU.
- `alu_b`  out  width  registered operand B to the ALU.
- `alu_op`  out  3  registered opcode to the ALU.
- `alu_y`  in  width  ALU result.
- `alu_onz`  in  3  ALU flags {overflow, negative, zero}.
- `flags`  out  3  flag register {O,N,Z}.
- `done`  out  1  one-cycle pulse in the writeback cycle.
- `dbg_addr`  in  3  debug read index.
- `dbg_data`  out  width  combinational `R[dbg_addr]`.

## Operation

- **States:** IDLE, READ, EXEC, WB.
- **IDLE**
  - `in_ready`=1; it is 0 in every other state.
  - Handshake fires on `in_valid && in_ready`. The instruction fields are latched into internal registers (`ld`, `op`, `rd`, `ra`, `rb`, `imm`).
  - Next state: WB if `in_ld`, else READ.
- **READ**
  - `opA <= R[ra]`, `opB <= R[rb]`, `alu_op <= op`.
  - Next state: EXEC.
- **EXEC**
  - `alu_a`/`alu_b`/`alu_op` have been stable since the previous edge.
  - `res <= alu_y` and `flags <= alu_onz`.
  - Next state: WB.
- **WB**
  - `R[rd] <= res`, or `R[rd] <= imm` if `ld`.
  - `done`=1 for this cycle only.
  - Next state: IDLE.
- **Flag register**
  - Updated only in EXEC, so every ALU op updates it, including and/or/xor/inc/mov.
  - Load-immediate leaves `flags` unchanged.
- **Register aliasing**
  - `rd` may equal `ra` and/or `rb`. Operands are sampled in READ, so the writeback never affects the operands of the same instruction.
- **Arithmetic and overflow**
  - All arithmetic is modulo 2^width and is performed by the ALU.
  - The sequencer does not recompute or alter `alu_onz`.
- **Idle inputs**
  - `in_valid` is ignored while `in_ready`=0.
  - Instruction fields are don't-care when `in_valid`=0.
- **Debug read port**
  - `dbg_data` is a combinational read. During WB it shows the old `R[rd]`; the new value is visible from the next cycle.

## Timing

- **Reset**
  - While `rst`=1 at an edge: state <= IDLE; all `R[i]`, `opA`, `opB`, `alu_op`, `res`, `flags` <= 0.
  - Resulting outputs: `done`=0, `in_ready`=1, `alu_a`=`alu_b`=0, `alu_op`=000, `flags`=000.
- **Reset mid-instruction** (READ/EXEC/WB): the instruction is discarded, with no writeback and no `done`.
- **Latency from accept edge T:**
  - ALU op: READ at T+1, EXEC at T+2, WB (`done`) at T+3, IDLE at T+4.
  - Load: WB (`done`) at T+1, IDLE at T+2.
- **Throughput:** one ALU op per 4 cycles; one load per 2 cycles.
- **Back-to-back:** no bubble beyond the IDLE cycle. An instruction held valid during WB is accepted in the following IDLE cycle.
- **ALU assumption:** the ALU is purely combinational. `alu_y`/`alu_onz` are sampled at the end of EXEC, one full cycle after the operands change.

## Test plan

All scenarios use width=8.

1. **Reset.** Assert `rst` for 2 cycles, then release. Expect `in_ready`=1, `flags`=000, `done`=0, and `dbg_data`=0x00 for every `dbg_addr` 0..7.
2. **Load and add.** Load R1=0x05, load R2=0x03, then add R3=R1+R2. Expect the add's `done` exactly 3 cycles after its accept, R3=0x08, `flags`=000. Each load's `done` comes 1 cycle after its accept, with `flags` unchanged.
3. **Signed overflow.** Load R1=0x7F and R2=0x01, then add R4=R1+R2. Expect R4=0x80, `flags`=110. Then sub R5=R4-R2: R5=0x7F, `flags`=100.
4. **Zero and aliasing.** sub R1=R1-R1 with R1=0x7F gives R1=0x00, `flags`=001. Load R6=0xFF, then inc R6=R6+1: R6=0x00, `flags`=001.
5. **Handshake stall.** Hold `in_valid`=1 continuously with two different ALU instructions. Expect `in_ready`=0 for 3 cycles after the first accept and the second accept exactly 4 cycles after the first. No instruction is lost or duplicated.
6. **Reset mid-op.** After loading R7=0x0A and accepting add R7=R7+R7, assert `rst` in EXEC. Expect no `done`, R7=0x00, `flags`=000, state IDLE next cycle.
